// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: opcodes, ALU codes, PC source
// selects and the control FSM state encoding.
package cpu_pkg;

    // Instruction opcodes (instr[15:12])
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU operation codes, shared with the ALU
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    // PC source selects
    localparam logic [1:0] PC_SRC_INC = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/control_decode.sv
// Opcode classifier: turns the 4-bit opcode into one-hot-ish class flags
// consumed by the control FSM.
module control_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_rtype,
    output logic       is_imm,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_halt,
    output logic       is_illegal
);

    // Classify the opcode; 0-5 are register-register ALU ops, B-E are undefined
    always_comb begin
        is_rtype   = (opcode <= OP_SLT);
        is_imm     = (opcode == OP_ADDI);
        is_load    = (opcode == OP_LW);
        is_store   = (opcode == OP_SW);
        is_branch  = (opcode == OP_BEQ);
        is_jump    = (opcode == OP_JMP);
        is_halt    = (opcode == OP_HALT);
        is_illegal = (opcode >= 4'hB) && (opcode <= 4'hE);
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable plus the ALU op and operand-B select.
module control_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_load,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [3:0]  alu_control,
    output logic        alu_src_b,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic        halted,
    output logic [2:0]  state
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] opcode;
    logic       is_rtype;
    logic       is_imm;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       is_halt;
    logic       is_illegal;

    assign opcode = instr[15:12];

    control_decode u_decode (
        .opcode     (opcode),
        .is_rtype   (is_rtype),
        .is_imm     (is_imm),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_branch  (is_branch),
        .is_jump    (is_jump),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    // State register; reset forces FETCH on the first edge with rst high
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Every output is held low during reset, including the debug state view
    assign state = rst ? 3'd0 : state_q;

    // Next-state and output decode; reset overrides all outputs so an
    // outstanding request is dropped in the same cycle rst rises
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_load     = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_INC;
        alu_control = ALU_ADD;
        alu_src_b   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                iord    = 1'b0;
                if (mem_ready) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_INC;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_halt) begin
                    state_d = ST_HALT;
                end else if (is_jump) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JMP;
                    state_d  = ST_FETCH;
                end else if (is_illegal) begin
                    illegal = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_rtype) begin
                    alu_control = opcode;
                    alu_src_b   = 1'b0;
                    state_d     = ST_WB;
                end else if (is_imm) begin
                    alu_control = ALU_ADD;
                    alu_src_b   = 1'b1;
                    state_d     = ST_WB;
                end else if (is_load || is_store) begin
                    alu_control = ALU_ADD;
                    alu_src_b   = 1'b1;
                    state_d     = ST_MEM;
                end else if (is_branch) begin
                    alu_control = ALU_SUB;
                    alu_src_b   = 1'b0;
                    pc_src      = PC_SRC_BR;
                    pc_write    = zero;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                alu_control = ALU_ADD;
                alu_src_b   = 1'b1;
                mem_req     = 1'b1;
                iord        = 1'b1;
                mem_we      = is_store;
                if (mem_ready) begin
                    state_d = is_store ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (rst) begin
            state_d     = ST_FETCH;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            iord        = 1'b0;
            ir_load     = 1'b0;
            pc_write    = 1'b0;
            pc_src      = PC_SRC_INC;
            alu_control = ALU_ADD;
            alu_src_b   = 1'b0;
            reg_write   = 1'b0;
            mem_to_reg  = 1'b0;
            illegal     = 1'b0;
            halted      = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: each driven cycle pushes the expected
// output vector; a negedge monitor pops and compares against the DUT.
module tb_control_fsm;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_load;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [3:0]  alu_control;
    logic        alu_src_b;
    logic        reg_write;
    logic        mem_to_reg;
    logic        illegal;
    logic        halted;
    logic [2:0]  state;

    typedef struct {
        string       tag;
        logic [18:0] vec;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [18:0] obs;

    control_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .iord        (iord),
        .ir_load     (ir_load),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .alu_src_b   (alu_src_b),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .illegal     (illegal),
        .halted      (halted),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {state, mem_req, mem_we, iord, ir_load, pc_write, pc_src,
                  alu_control, alu_src_b, reg_write, mem_to_reg, illegal, halted};

    // Expected vector, fields in the same order as obs
    function automatic logic [18:0] v(int s, int req, int we, int io, int irl,
                                      int pcw, int pcs, int alu, int srcb,
                                      int rw, int m2r, int ill, int hlt);
        logic [2:0] s3;
        logic [1:0] p2;
        logic [3:0] a4;
        s3 = s[2:0];
        p2 = pcs[1:0];
        a4 = alu[3:0];
        return {s3, req[0], we[0], io[0], irl[0], pcw[0], p2, a4,
                srcb[0], rw[0], m2r[0], ill[0], hlt[0]};
    endfunction

    task automatic check_vec(input string tag, input logic [18:0] got,
                             input logic [18:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b required=%b (state|req we iord irl pcw|pcsrc|alu|srcb rw m2r ill hlt)",
                     tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge and queue
    // the outputs expected for that cycle
    task automatic step(input logic r, input logic rdy, input logic z,
                        input logic [15:0] ins, input logic [18:0] exp,
                        input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        zero      = z;
        instr     = ins;
        e.tag     = tag;
        e.vec     = exp;
        sb.push_back(e);
    endtask

    // Compare the oldest queued expectation mid-cycle, away from the edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_vec(e.tag, obs, e.vec);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] zv, f_ok, f_wait, dec;
        zv     = v(0,0,0,0,0,0,0,0,0,0,0,0,0);
        f_ok   = v(0,1,0,0,1,1,0,0,0,0,0,0,0);
        f_wait = v(0,1,0,0,0,0,0,0,0,0,0,0,0);
        dec    = v(1,0,0,0,0,0,0,0,0,0,0,0,0);

        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; instr = 16'h0000;

        // Reset held with mem_ready high: everything low, no request
        step(1, 1, 0, 16'h0000, zv, "reset0");
        step(1, 1, 0, 16'h0000, zv, "reset1");

        // ADD: 0,1,2,4
        step(0, 1, 0, 16'h0123, f_ok, "add_fetch");
        step(0, 1, 0, 16'h0123, dec, "add_decode");
        step(0, 1, 0, 16'h0123, v(2,0,0,0,0,0,0,0,0,0,0,0,0), "add_exec");
        step(0, 1, 0, 16'h0123, v(4,0,0,0,0,0,0,0,0,1,0,0,0), "add_wb");

        // LW with two MEM wait cycles
        step(0, 1, 0, 16'h7012, f_ok, "lw_fetch");
        step(0, 1, 0, 16'h7012, dec, "lw_decode");
        step(0, 1, 0, 16'h7012, v(2,0,0,0,0,0,0,0,1,0,0,0,0), "lw_exec");
        step(0, 0, 0, 16'h7012, v(3,1,0,1,0,0,0,0,1,0,0,0,0), "lw_mem_w1");
        step(0, 0, 0, 16'h7012, v(3,1,0,1,0,0,0,0,1,0,0,0,0), "lw_mem_w2");
        step(0, 1, 0, 16'h7012, v(3,1,0,1,0,0,0,0,1,0,0,0,0), "lw_mem_rdy");
        step(0, 1, 0, 16'h7012, v(4,0,0,0,0,0,0,0,0,1,1,0,0), "lw_wb");

        // BEQ taken then not taken
        step(0, 1, 0, 16'h9003, f_ok, "beq1_fetch");
        step(0, 1, 1, 16'h9003, dec, "beq1_decode");
        step(0, 1, 1, 16'h9003, v(2,0,0,0,0,1,1,1,0,0,0,0,0), "beq1_exec");
        step(0, 1, 1, 16'h9003, f_ok, "beq0_fetch");
        step(0, 1, 0, 16'h9003, dec, "beq0_decode");
        step(0, 1, 0, 16'h9003, v(2,0,0,0,0,0,1,1,0,0,0,0,0), "beq0_exec");

        // JMP, with one FETCH wait beforehand
        step(0, 0, 0, 16'hA055, f_wait, "jmp_fetch_w");
        step(0, 1, 0, 16'hA055, f_ok, "jmp_fetch");
        step(0, 1, 0, 16'hA055, v(1,0,0,0,0,1,2,0,0,0,0,0,0), "jmp_decode");

        // SLT and ADDI
        step(0, 1, 0, 16'h5678, f_ok, "slt_fetch");
        step(0, 1, 0, 16'h5678, dec, "slt_decode");
        step(0, 1, 0, 16'h5678, v(2,0,0,0,0,0,0,5,0,0,0,0,0), "slt_exec");
        step(0, 1, 0, 16'h5678, v(4,0,0,0,0,0,0,0,0,1,0,0,0), "slt_wb");
        step(0, 1, 0, 16'h6abc, f_ok, "addi_fetch");
        step(0, 1, 0, 16'h6abc, dec, "addi_decode");
        step(0, 1, 0, 16'h6abc, v(2,0,0,0,0,0,0,0,1,0,0,0,0), "addi_exec");
        step(0, 1, 0, 16'h6abc, v(4,0,0,0,0,0,0,0,0,1,0,0,0), "addi_wb");

        // Illegal opcode pulses once, then HALT
        step(0, 1, 0, 16'hC000, f_ok, "ill_fetch");
        step(0, 1, 0, 16'hC000, v(1,0,0,0,0,0,0,0,0,0,0,1,0), "ill_decode");
        step(0, 1, 0, 16'hF000, f_ok, "halt_fetch");
        step(0, 1, 0, 16'hF000, dec, "halt_decode");
        for (int i = 0; i < 20; i++) begin
            step(0, i[0], 0, 16'hF000, v(5,0,0,0,0,0,0,0,0,0,0,0,1), "halt_hold");
        end

        // Leave HALT through reset; first fetch the cycle after rst falls
        step(1, 1, 0, 16'hF000, zv, "halt_rst");
        step(0, 1, 0, 16'h8123, f_ok, "sw_fetch");
        step(0, 1, 0, 16'h8123, dec, "sw_decode");
        step(0, 1, 0, 16'h8123, v(2,0,0,0,0,0,0,0,1,0,0,0,0), "sw_exec");
        step(0, 0, 0, 16'h8123, v(3,1,1,1,0,0,0,0,1,0,0,0,0), "sw_mem_w1");
        // rst on the second wait cycle drops the request immediately
        step(1, 0, 0, 16'h8123, zv, "sw_mem_rst");
        step(0, 1, 0, 16'h8123, f_ok, "post_rst_fetch");
        step(0, 1, 0, 16'h8123, dec, "post_rst_decode");
        step(0, 1, 0, 16'h8123, v(2,0,0,0,0,0,0,0,1,0,0,0,0), "sw2_exec");
        step(0, 1, 0, 16'h8123, v(3,1,1,1,0,0,0,0,1,0,0,0,0), "sw2_mem");
        step(0, 1, 0, 16'h0000, f_ok, "sw2_next_fetch");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the 16-bit CPU. It sits directly upstream of the ALU and drives its 4-bit `alu_control` code and operand-B select. It sequences fetch, decode, execute, memory and writeback for one instruction at a time, and consumes the ALU `zero` flag to resolve branches. All datapath enables (PC, IR, register file, memory request) come from this block.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr  in  16  IR contents; opcode = instr[15:12]; valid from DECODE until the next FETCH completes
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the outstanding request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, qualified by mem_req
- iord  out  1  memory address select: 0 = PC, 1 = ALU result
- ir_load  out  1  load IR from memory read data
- pc_write  out  1  load PC
- pc_src  out  2  0 = PC+1, 1 = branch target, 2 = jump target
- alu_control  out  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT
- alu_src_b  out  1  0 = register B, 1 = sign-extended immediate
- reg_write  out  1  register-file write enable
- mem_to_reg  out  1  writeback source: 0 = ALU, 1 = memory
- illegal  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  high while in HALT
- state  out  3  current state, for debug

## Operation
- Opcodes: 0–5 are R-type, with alu_control = opcode. 6 ADDI, 7 LW, 8 SW, 9 BEQ, A JMP, F HALT. B–E are illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Unlisted outputs are 0 in each state.
- FETCH:
  - mem_req=1, iord=0.
  - If mem_ready: ir_load=1, pc_write=1, pc_src=0, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (exactly one cycle):
  - F → HALT.
  - A → pc_write=1, pc_src=2, go to FETCH.
  - B–E → illegal=1, go to FETCH.
  - Anything else → EXEC.
- EXEC:
  - R-type: alu_control=opcode, alu_src_b=0.
  - ADDI/LW/SW: alu_control=0, alu_src_b=1.
  - BEQ: alu_control=1, alu_src_b=0, pc_src=1, pc_write=zero, then go to FETCH.
  - LW/SW → MEM; R-type/ADDI → WB.
- MEM:
  - alu_control=0, alu_src_b=1, mem_req=1, iord=1, mem_we=(opcode==8).
  - Wait for mem_ready; on ready, SW → FETCH, LW → WB.
- WB: reg_write=1, mem_to_reg=(opcode==7), go to FETCH.
- HALT: halted=1, no memory requests; leave only on rst.
- Output timing classes:
  - ir_load and pc_write in FETCH depend on mem_ready (Mealy).
  - pc_write in EXEC for BEQ depends on zero (Mealy).
  - All other outputs are a function of state and opcode only.

## Timing
- Reset:
  - While rst=1, every output is 0, including mem_req.
  - The state register becomes FETCH on the first edge with rst=1.
  - The first request is issued in the cycle after rst falls.
- Cycles per instruction with zero-wait memory: R-type/ADDI 4, LW 5, SW 4, BEQ 3, JMP 2, HALT 2 (then stays). Each cycle with mem_ready=0 in FETCH or MEM adds one cycle.
- Memory handshake:
  - mem_req and the address/strobe stay stable until the cycle in which mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
  - Exactly one ir_load per completed fetch.
- rst during a wait cycle of FETCH or MEM drops the request in that same cycle. No pc_write, reg_write or mem_we may follow.
- BEQ with zero=0: pc_write stays 0, so PC keeps PC+1 from FETCH.
- illegal is asserted for exactly one cycle per illegal instruction. PC has already advanced, so execution continues.
- `state` equals the registered state encoding. It is not affected by mem_ready or zero within a cycle.

## Structure
- Shared `cpu_pkg` holds:
  - opcode constants (OP_ADD … OP_HALT)
  - ALU codes ALU_ADD=0 … ALU_SLT=5, shared with the ALU
  - state encoding
  - PC_SRC_* codes
- One combinational sub-module, `control_decode`: opcode → is_rtype, is_imm, is_load, is_store, is_branch, is_jump, is_halt, is_illegal. The FSM consumes these flags.

## Test plan
- Reset with mem_ready=1, then opcode 0 (ADD):
  - state sequence 0,1,2,4,0
  - alu_control=0 in EXEC, reg_write=1 only in WB
  - 4 cycles total
- LW (0x7…) with mem_ready low for 2 cycles in MEM:
  - mem_req=1, iord=1, mem_we=0 held for 3 cycles
  - WB has mem_to_reg=1
  - 7 cycles total
- BEQ with zero=1, then BEQ with zero=0:
  - EXEC shows alu_control=1, pc_src=1
  - pc_write=1 then 0
  - 3 cycles each, no reg_write
- Opcode 0xC, then 0xF:
  - illegal pulses once in DECODE, return to FETCH
  - HALT reached, halted=1
  - mem_req stays 0 for 20 cycles
- rst asserted during the second wait cycle of an SW MEM stage:
  - mem_req=0 that cycle, no mem_we pulse
  - state=0 after the edge
  - first fetch issued the cycle after rst falls
- Opcode 6 (ADDI) and opcode 5 (SLT):
  - EXEC shows alu_src_b=1/alu_control=0 for ADDI
  - EXEC shows alu_src_b=0/alu_control=5 for SLT
